// File: rtl/rs_latch_pkg.sv
// Shared types and default timing constants for the RS latch controller.
package rs_latch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  localparam int unsigned PULSE_CYCLES_DEF  = 2;
  localparam int unsigned SETTLE_CYCLES_DEF = 3;
  localparam int unsigned MAX_RETRY_DEF     = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs_latch_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rs_latch_ctrl.sv
// Drives an external RS latch with timed set/reset pulses and confirms the
// result through synchronized feedback, retrying a bounded number of times.
module rs_latch_ctrl
  import rs_latch_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = PULSE_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic set_req,
  input  logic rst_req,
  input  logic q_fb,
  input  logic q_bar_fb,
  output logic latch_set,
  output logic latch_reset,
  output logic busy,
  output logic done,
  output logic err,
  output logic q_state
);

  localparam int unsigned CW =
    cnt_width((PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES);
  localparam int unsigned RW = cnt_width(MAX_RETRY + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
  logic            retry_q, retry_d;
  logic            target_q, target_d;
  logic            last_set_q, last_set_d;
  logic            pend_set_q, pend_set_d;
  logic            pend_rst_q, pend_rst_d;
  logic            qv_q, qv_d;
  logic            q_state_q, q_state_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            latch_set_q, latch_set_d;
  logic            latch_reset_q, latch_reset_d;

  logic q_sync, qb_sync;
  logic grant_c, grant_set_c, skip_c, tgt_c, pass_c;

  sync2 u_sync_q (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (q_fb),
    .q_o   (q_sync)
  );

  sync2 u_sync_qb (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (q_bar_fb),
    .q_o   (qb_sync)
  );

  // Round-robin between directions; last_set_q resets low so set wins first.
  assign grant_c     = pend_set_q | pend_rst_q;
  assign grant_set_c = pend_set_q & (~pend_rst_q | ~last_set_q);
  assign skip_c      = qv_q & (grant_set_c == q_state_q);
  assign tgt_c       = (state_q == ST_IDLE) ? grant_set_c : target_q;
  assign pass_c      = (q_sync == tgt_c) & (qb_sync == ~tgt_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_c) state_d = skip_c ? ST_CHECK : ST_PULSE;
      ST_PULSE:  if (cnt_q == CW'(PULSE_CYCLES - 1)) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = ST_CHECK;
      ST_CHECK:  state_d = retry_q ? ST_PULSE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Verdict is taken on the edge entering CHECK so done lines up with CHECK.
  always_comb begin
    pend_set_d  = pend_set_q | set_req;
    pend_rst_d  = pend_rst_q | rst_req;
    target_d    = target_q;
    last_set_d  = last_set_q;
    retry_cnt_d = retry_cnt_q;
    retry_d     = 1'b0;
    qv_d        = qv_q;
    q_state_d   = q_state_q;
    err_d       = err_q;
    done_d      = 1'b0;
    cnt_d       = '0;

    if ((state_d == state_q) && ((state_q == ST_PULSE) || (state_q == ST_SETTLE)))
      cnt_d = cnt_q + CW'(1);

    // A repeat request landing on its own grant edge merges into that grant.
    if ((state_q == ST_IDLE) && grant_c) begin
      target_d   = grant_set_c;
      last_set_d = grant_set_c;
      if (grant_set_c) pend_set_d = 1'b0;
      else             pend_rst_d = 1'b0;
    end

    if (state_d == ST_CHECK) begin
      if (pass_c) begin
        done_d      = 1'b1;
        q_state_d   = tgt_c;
        qv_d        = 1'b1;
        retry_cnt_d = '0;
      end else if (retry_cnt_q < RW'(MAX_RETRY)) begin
        retry_d     = 1'b1;
        retry_cnt_d = retry_cnt_q + RW'(1);
      end else begin
        done_d      = 1'b1;
        err_d       = 1'b1;
        retry_cnt_d = '0;
      end
    end

    latch_set_d   = (state_d == ST_PULSE) &  target_d;
    latch_reset_d = (state_d == ST_PULSE) & ~target_d;
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      retry_cnt_q   <= '0;
      retry_q       <= 1'b0;
      target_q      <= 1'b0;
      last_set_q    <= 1'b0;
      pend_set_q    <= 1'b0;
      pend_rst_q    <= 1'b0;
      qv_q          <= 1'b0;
      q_state_q     <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      latch_set_q   <= 1'b0;
      latch_reset_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      retry_q       <= retry_d;
      target_q      <= target_d;
      last_set_q    <= last_set_d;
      pend_set_q    <= pend_set_d;
      pend_rst_q    <= pend_rst_d;
      qv_q          <= qv_d;
      q_state_q     <= q_state_d;
      err_q         <= err_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      latch_set_q   <= latch_set_d;
      latch_reset_q <= latch_reset_d;
    end
  end

  assign latch_set   = latch_set_q;
  assign latch_reset = latch_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign q_state     = q_state_q;

endmodule

// File: tb/tb_rs_latch_ctrl.sv
// Directed-vector bench for rs_latch_ctrl with a behavioural RS latch model.
// Observed vector bit order: {latch_set, latch_reset, busy, done, err, q_state}.
module tb_rs_latch_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic set_req = 1'b0;
  logic rst_req = 1'b0;
  logic q_fb, q_bar_fb;
  logic latch_set, latch_reset, busy, done, err, q_state;
  logic lat = 1'b0;
  logic stuck_lo = 1'b0;
  logic [5:0] obs;
  int n_vec = 0;
  int n_err = 0;

  rs_latch_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .set_req     (set_req),
    .rst_req     (rst_req),
    .q_fb        (q_fb),
    .q_bar_fb    (q_bar_fb),
    .latch_set   (latch_set),
    .latch_reset (latch_reset),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .q_state     (q_state)
  );

  always #5 clk = ~clk;

  // External latch: remembers the last drive; stuck_lo pins the outputs at 0.
  always @(posedge latch_set or posedge latch_reset) lat = latch_set;
  assign q_fb     = lat & ~stuck_lo;
  assign q_bar_fb = ~lat | stuck_lo;

  assign obs = {latch_set, latch_reset, busy, done, err, q_state};

  task automatic check_vec(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] exp);
    @(posedge clk);
    #2;
    check_vec(tag, obs, exp);
  endtask

  task automatic step_n(input string tag, input logic [5:0] exp, input int n);
    for (int i = 0; i < n; i++) step(tag, exp);
  endtask

  // Set then reset served back-to-back, starting from q_state=0.
  task automatic set_then_rst_tail(input string tag);
    step(tag, 6'b001101);
    step(tag, 6'b000001);
    step_n(tag, 6'b011001, 2);
    step_n(tag, 6'b001001, 3);
    step(tag, 6'b001100);
    step(tag, 6'b000000);
  endtask

  initial begin
    // Reset state
    #3 check_vec("rst.hold", obs, 6'b000000);
    step_n("rst.hold", 6'b000000, 2);
    reset_n = 1'b1;
    step_n("rst.idle", 6'b000000, 2);

    // Simultaneous set and reset: set first, then reset, never overlapping
    set_req = 1'b1; rst_req = 1'b1;
    step("both.cap", 6'b000000);
    set_req = 1'b0; rst_req = 1'b0;
    step_n("both.pulse", 6'b101000, 2);
    step_n("both.settle", 6'b001000, 3);
    set_then_rst_tail("both.tail");

    // Reset request arriving during SETTLE of a set is held and served next
    set_req = 1'b1;
    step("late.cap", 6'b000000);
    set_req = 1'b0;
    step_n("late.pulse", 6'b101000, 2);
    step("late.settle", 6'b001000);
    rst_req = 1'b1;
    step("late.settle", 6'b001000);
    rst_req = 1'b0;
    step("late.settle", 6'b001000);
    set_then_rst_tail("late.tail");

    // Reset mid-pulse drops the drive at once and loses the pending request
    set_req = 1'b1;
    step("arst.cap", 6'b000000);
    set_req = 1'b0; rst_req = 1'b1;
    step("arst.pulse", 6'b101000);
    rst_req = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_vec("arst.drop", obs, 6'b000000);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    step_n("arst.lost", 6'b000000, 8);

    // Feedback stuck low: 1 + 2 retries, then err with done, q_state kept
    stuck_lo = 1'b1;
    set_req = 1'b1;
    step("stuck.cap", 6'b000000);
    set_req = 1'b0;
    for (int p = 0; p < 2; p++) begin
      step_n("stuck.pulse", 6'b101000, 2);
      step_n("stuck.wait", 6'b001000, 4);
    end
    step_n("stuck.pulse", 6'b101000, 2);
    step_n("stuck.settle", 6'b001000, 3);
    step("stuck.err", 6'b001110);
    step("stuck.idle", 6'b000010);
    stuck_lo = 1'b0;
    step_n("stuck.sticky", 6'b000010, 3);
    #1 reset_n = 1'b0;
    #1 check_vec("stuck.clr", obs, 6'b000000);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Plain set with passing feedback: drive 2 cycles, done 6 after request
    set_req = 1'b1;
    step("set.cap", 6'b000000);
    set_req = 1'b0;
    step_n("set.pulse", 6'b101000, 2);
    step_n("set.settle", 6'b001000, 3);
    step("set.done", 6'b001101);
    step("set.idle", 6'b000001);

    // Set again while confirmed set: no drive pulse, straight to the check
    set_req = 1'b1;
    step("skip.cap", 6'b000001);
    set_req = 1'b0;
    step("skip.done", 6'b001101);
    step_n("skip.idle", 6'b000001, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
